// File: rtl/decoder_3to8_pkg.sv
// -----------------------------------------------------------------------------
// decoder_3to8_pkg
// Shared constants for the registered 3-to-8 one-hot decoder.
//   DEC_IN_W  : width of the select code
//   DEC_OUT_N : number of one-hot output lines
// -----------------------------------------------------------------------------
package decoder_3to8_pkg;

    localparam int DEC_IN_W  = 3;
    localparam int DEC_OUT_N = 8;

endpackage : decoder_3to8_pkg

// File: rtl/decoder_3to8_comb.sv
// -----------------------------------------------------------------------------
// decoder_3to8_comb
// Purely combinational decode of a 3-bit select code into an 8-bit one-hot
// vector. Bit k of one_hot is set iff code == k.
// Ports:
//   code    : select code, code[2] is the MSB
//   one_hot : one-hot decode of code
// -----------------------------------------------------------------------------
module decoder_3to8_comb
    import decoder_3to8_pkg::*;
(
    input  logic [DEC_IN_W-1:0]  code,
    output logic [DEC_OUT_N-1:0] one_hot
);

    // Table-driven one-hot decode of the select code
    always_comb begin
        one_hot = 8'b0000_0000;
        case (code)
            3'd0:    one_hot = 8'b0000_0001;
            3'd1:    one_hot = 8'b0000_0010;
            3'd2:    one_hot = 8'b0000_0100;
            3'd3:    one_hot = 8'b0000_1000;
            3'd4:    one_hot = 8'b0001_0000;
            3'd5:    one_hot = 8'b0010_0000;
            3'd6:    one_hot = 8'b0100_0000;
            3'd7:    one_hot = 8'b1000_0000;
            // Only reachable with X/Z on code; drive a safe all-zero vector
            default: one_hot = 8'b0000_0000;
        endcase
    end

endmodule : decoder_3to8_comb

// File: rtl/decoder_3to8.sv
// -----------------------------------------------------------------------------
// decoder_3to8
// Registered 3-to-8 one-hot decoder for the ALU control path. The select code
// is decoded combinationally and captured on the rising clock edge, so every
// output comes straight from a flop (glitch-free, 1-cycle latency).
// Ports:
//   clk    : system clock, rising-edge active
//   reset  : synchronous active-high reset, priority over en
//   en     : decode enable; when low all outputs hold
//   in     : 3-bit select code, in[2] is the MSB
//   d0..d7 : one-hot lines, dk high when the captured code equals k
//   valid  : high once a decode has been captured since the last reset
// -----------------------------------------------------------------------------
module decoder_3to8
    import decoder_3to8_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [DEC_IN_W-1:0] in,
    output logic                d0,
    output logic                d1,
    output logic                d2,
    output logic                d3,
    output logic                d4,
    output logic                d5,
    output logic                d6,
    output logic                d7,
    output logic                valid
);

    logic [DEC_OUT_N-1:0] one_hot_s;
    logic [DEC_OUT_N-1:0] dec_r;
    logic                 valid_r;

    decoder_3to8_comb u_comb (
        .code    (in),
        .one_hot (one_hot_s)
    );

    // Capture the decoded vector and track whether any decode has happened
    always_ff @(posedge clk) begin
        if (reset) begin
            dec_r   <= 8'b0000_0000;
            valid_r <= 1'b0;
        end else if (en) begin
            dec_r   <= one_hot_s;
            valid_r <= 1'b1;
        end else begin
            dec_r   <= dec_r;
            valid_r <= valid_r;
        end
    end

    // Outputs are plain fan-out of the flops; no logic after the register
    assign d0    = dec_r[0];
    assign d1    = dec_r[1];
    assign d2    = dec_r[2];
    assign d3    = dec_r[3];
    assign d4    = dec_r[4];
    assign d5    = dec_r[5];
    assign d6    = dec_r[6];
    assign d7    = dec_r[7];
    assign valid = valid_r;

endmodule : decoder_3to8

// File: tb/tb_decoder_3to8.sv
// -----------------------------------------------------------------------------
// tb_decoder_3to8
// Scoreboard bench for decoder_3to8: each driven vector pushes the expected
// {valid, d7..d0} into a queue at the capturing edge; the entry is popped and
// compared against the DUT on the following falling edge.
// -----------------------------------------------------------------------------
module tb_decoder_3to8;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] in;
    logic       d0, d1, d2, d3, d4, d5, d6, d7;
    logic       valid;

    logic [8:0] exp_q[$];
    logic [7:0] model_d;
    logic       model_valid;
    int         vec_cnt;
    int         err_cnt;

    decoder_3to8 dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .in    (in),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .d4    (d4),
        .d5    (d5),
        .d6    (d6),
        .d7    (d7),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] observed();
        return {valid, d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    // Single comparison point: counts the vector and reports any miscompare
    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    // Drive one vector, update the reference at the edge, compare on negedge
    task automatic step(input string tag, input logic r, input logic e, input logic [2:0] code);
        logic [8:0] exp_v;
        reset = r;
        en    = e;
        in    = code;
        @(posedge clk);
        if (r) begin
            model_d     = 8'h00;
            model_valid = 1'b0;
        end else if (e) begin
            model_d     = 8'h01 << code;
            model_valid = 1'b1;
        end
        exp_q.push_back({model_valid, model_d});
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({tag, "_qempty"}, 9'h1FF, 9'h000);
        end else begin
            exp_v = exp_q.pop_front();
            check(tag, observed(), exp_v);
            if (valid === 1'b1)
                check({tag, "_onehot"}, 9'($countones(observed() & 9'h0FF)), 9'd1);
        end
    endtask

    initial begin
        vec_cnt     = 0;
        err_cnt     = 0;
        model_d     = 8'h00;
        model_valid = 1'b0;
        reset       = 1'b1;
        en          = 1'b1;
        in          = 3'b101;
        @(negedge clk);

        // Reset held with en=1, in=5: everything stays zero
        step("reset0", 1'b1, 1'b1, 3'b101);
        step("reset1", 1'b1, 1'b1, 3'b101);

        // Exhaustive sweep, back-to-back enabled codes
        for (int k = 0; k < 8; k++)
            step($sformatf("sweep%0d", k), 1'b0, 1'b1, 3'(k));

        // Hold: capture 2, then disabled with in=7 for three cycles
        step("hold_cap", 1'b0, 1'b1, 3'b010);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("hold%0d", k), 1'b0, 1'b0, 3'b111);
            check($sformatf("hold%0d_d2d7", k), {7'd0, d2, d7}, 9'b0_0000_0010);
        end

        // Mid-operation reset while enabled, then recover with code 0
        step("mid_d5", 1'b0, 1'b1, 3'b101);
        step("mid_rst", 1'b1, 1'b1, 3'b101);
        check("mid_rst_zero", observed(), 9'h000);
        step("mid_rec", 1'b0, 1'b1, 3'b000);
        check("mid_rec_d0", {8'd0, d0}, 9'd1);

        // Disabled edges right after reset keep outputs at zero
        step("post_rst", 1'b1, 1'b0, 3'b011);
        step("idle0", 1'b0, 1'b0, 3'b011);
        step("idle1", 1'b0, 1'b0, 3'b100);

        // Random en/in with occasional reset against the reference model
        for (int i = 0; i < 1000; i++)
            step("rand", ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_decoder_3to8

// File: doc/decoder_3to8.md
Name: decoder_3to8

Overview:
Registered 3-to-8 one-hot decoder for the ALU control path: converts a 3-bit select code into eight individual one-hot lines d0..d7. The input is decoded combinationally and captured on the rising clock edge, so outputs are glitch-free and aligned to the clock. It sits between the opcode/select source and the ALU function-enable lines.

Parameters:
- None. Input width is fixed at 3 and output count at 8.

Ports:
- clk    input   1  system clock; all state updates on its rising edge
- reset  input   1  synchronous, active-high reset
- en     input   1  decode enable; when low, outputs hold their previous value
- in     input   3  select code, in[2] is the MSB
- d0     output  1  high when registered code == 0
- d1     output  1  high when registered code == 1
- d2     output  1  high when registered code == 2
- d3     output  1  high when registered code == 3
- d4     output  1  high when registered code == 4
- d5     output  1  high when registered code == 5
- d6     output  1  high when registered code == 6
- d7     output  1  high when registered code == 7
- valid  output  1  high once at least one decode has been captured since reset

Behaviour:
- One clock, synchronous active-high reset: reset is sampled only on the rising edge of clk.
- Reset value: d0..d7 = 0 and valid = 0. Reset has priority over en.
- Decode function: dk = 1 iff in == k, for k = 0..7. Exactly one of d0..d7 is high whenever valid = 1.
- Latency: 1 cycle. If en = 1 at edge N, outputs reflect the value of in sampled at edge N and are visible after edge N.
- When en = 0 at an edge, d0..d7 and valid hold their previous values. After reset, outputs stay all-zero until the first enabled edge.
- valid is set on the first enabled, non-reset edge. It stays high until the next reset.
- Reset asserted mid-operation clears all outputs at that edge, regardless of en or in.
- X/Z on in with en = 1 is not supported; no defined output is required.
- No combinational path from any input to any output; all outputs are driven directly from flops.
- Back-to-back enabled codes are supported at full rate, one new code per cycle, with no bubbles.

Decomposition:
- Shared package holds only two constants:
  - DEC_IN_W = 3
  - DEC_OUT_N = 8
- One natural sub-module, decoder_3to8_comb: a purely combinational decode of in into an 8-bit one-hot vector. The top level registers that vector, fans it out to d0..d7, and maintains valid.

Test Plan:
- Reset: hold reset = 1 for 2 cycles with en = 1 and in = 3'b101. Required: d0..d7 = 0 and valid = 0 throughout.
- Exhaustive sweep: reset released, en = 1, apply in = 0..7 on consecutive cycles. Required: one cycle after each code k, only dk = 1 (e.g. in = 3'b110 gives d6 = 1, all others 0), and valid = 1 from the first capture onward.
- Hold: capture in = 3'b010 (d2 = 1), then set en = 0 and drive in = 3'b111 for 3 cycles. Required: d2 stays 1, d7 stays 0.
- Mid-operation reset: with d5 = 1, assert reset for 1 cycle while en = 1. Required: all outputs 0 and valid = 0 after that edge. The next enabled edge with in = 0 gives d0 = 1.
- One-hot invariant: random in/en for 1000 cycles. Required: whenever valid = 1, the popcount of d0..d7 is exactly 1, and the outputs match a 1-cycle-delayed reference model.
